// File: rtl/onebyfour_demux_router.sv
// onebyfour_demux_router: registered 1-to-4 demultiplexer.
// One valid/ready input stream is routed by S into four one-entry channel
// holding registers A/B/C/D. Each channel has its own valid/ready handshake,
// so a stalled consumer blocks only the words addressed to it.
// Optional feature: define DEMUX_BCAST_EN to add the bcast input, which loads
// Y into all four channels at once when every channel can take a word.
module onebyfour_demux_router #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] Y,
    input  logic [1:0]   S,
    input  logic         in_valid,
`ifdef DEMUX_BCAST_EN
    input  logic         bcast,
`endif
    output logic         in_ready,
    output logic [n-1:0] A,
    output logic [n-1:0] B,
    output logic [n-1:0] C,
    output logic [n-1:0] D,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic         busy
);

    logic [n-1:0] data_q [4];
    logic [n-1:0] data_d [4];
    logic [3:0]   vld_q;
    logic [3:0]   vld_d;
    logic [3:0]   load;
    logic [3:0]   drain;
    logic         sel_ready;
    logic         accept;

    // Handshake decode: ready depends only on the addressed channel(s), never on in_valid.
    always_comb begin
        sel_ready = !vld_q[S] || out_ready[S];
`ifdef DEMUX_BCAST_EN
        in_ready  = bcast ? (&(~vld_q | out_ready)) : sel_ready;
`else
        in_ready  = sel_ready;
`endif
        accept = in_valid && in_ready;
        drain  = vld_q & out_ready;
        for (int k = 0; k < 4; k++) begin
`ifdef DEMUX_BCAST_EN
            load[k] = accept && (bcast || (S == 2'(k)));
`else
            load[k] = accept && (S == 2'(k));
`endif
            // A same-edge load wins over a drain so each channel sustains 1 word/cycle.
            data_d[k] = load[k] ? Y : data_q[k];
        end
        vld_d = (vld_q & ~drain) | load;
    end

    // Channel holding registers and their valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Outputs come straight from flops, so busy is glitch-free.
    always_comb begin
        A         = data_q[0];
        B         = data_q[1];
        C         = data_q[2];
        D         = data_q[3];
        out_valid = vld_q;
        busy      = |vld_q;
    end

endmodule

// File: tb/tb_onebyfour_demux_router.sv
// tb_onebyfour_demux_router: scoreboard bench for onebyfour_demux_router.
// Accepted words are pushed into per-channel expected queues and popped when
// the channel drains; directed checks cover reset, backpressure and broadcast.
module tb_onebyfour_demux_router;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] Y;
    logic [1:0] S;
    logic       in_valid;
    logic       bcast;
    logic       in_ready;
    logic [3:0] A, B, C, D;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    logic [3:0] sbq [4][$];

    always #5 clk = ~clk;

    onebyfour_demux_router #(.n(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Y         (Y),
        .S         (S),
        .in_valid  (in_valid),
`ifdef DEMUX_BCAST_EN
        .bcast     (bcast),
`endif
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [3:0] chan(input int k);
        case (k)
            0: return A;
            1: return B;
            2: return C;
            default: return D;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        for (int k = 0; k < 4; k++) sbq[k].delete();
    endtask

    // Scoreboard monitor: compare at the falling edge, then advance the model
    // to reflect the transfers the coming rising edge will perform.
    always @(negedge clk) begin
        if (mon_en) begin
            logic       exp_rdy;
            logic       all_rdy;
            logic       is_bc;
            all_rdy = 1'b1;
            for (int k = 0; k < 4; k++)
                if (sbq[k].size() != 0 && !out_ready[k]) all_rdy = 1'b0;
`ifdef DEMUX_BCAST_EN
            is_bc = bcast;
`else
            is_bc = 1'b0;
`endif
            exp_rdy = is_bc ? all_rdy : (sbq[S].size() == 0 || out_ready[S]);
            chk("in_ready", in_ready, exp_rdy);
            chk("busy", busy, (sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("out_valid[%0d]", k), out_valid[k], sbq[k].size() != 0);
                if (sbq[k].size() != 0)
                    chk($sformatf("data[%0d]", k), chan(k), sbq[k][0]);
            end
            for (int k = 0; k < 4; k++)
                if (sbq[k].size() != 0 && out_ready[k]) void'(sbq[k].pop_front());
            if (in_valid && exp_rdy) begin
                for (int k = 0; k < 4; k++)
                    if (is_bc || S == 2'(k)) sbq[k].push_back(Y);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        Y         = '0;
        S         = '0;
        in_valid  = 1'b0;
        bcast     = 1'b0;
        out_ready = 4'b0000;
        #1;
        chk("rst out_valid", out_valid, 4'b0000);
        chk("rst busy", busy, 1'b0);
        chk("rst data", {A, B, C, D}, 16'h0000);
        step();
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();

        // Basic routing, one word per channel on consecutive cycles.
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            Y = 4'(i + 1); S = 2'(i); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        // Backpressure on channel C.
        out_ready = 4'b1011;
        Y = 4'h9; S = 2'd2; in_valid = 1'b1;
        step();
        Y = 4'h5;
        #1;
        chk("bp C held", C, 4'h9);
        chk("bp in_ready low", in_ready, 1'b0);
        step();
        chk("bp still stalled", in_ready, 1'b0);
        out_ready = 4'b1111;
        step();
        in_valid = 1'b0; out_ready = 4'b1011;
        #1;
        chk("bp C replaced", C, 4'h5);

        // Independence: C full and stalled, traffic to A flows.
        Y = 4'hA; S = 2'd0; in_valid = 1'b1;
        #1;
        chk("indep in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        #1;
        chk("indep A", A, 4'hA);
        chk("indep C kept", C, 4'h5);
        chk("indep C valid", out_valid[2], 1'b1);
        out_ready = 4'b1111;
        step();
        step();

        // Throughput: 8 back-to-back words to B.
        for (int i = 0; i < 8; i++) begin
            Y = 4'((i * 3 + 2) & 15); S = 2'd1; in_valid = 1'b1;
            #1;
            chk("tput in_ready", in_ready, 1'b1);
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        // Asynchronous reset while B holds 7.
        out_ready = 4'b0000;
        Y = 4'h7; S = 2'd1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        chk("pre-rst B", B, 4'h7);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("arst out_valid", out_valid, 4'b0000);
        chk("arst B", B, 4'h0);
        chk("arst busy", busy, 1'b0);
        clear_sb();
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();

`ifdef DEMUX_BCAST_EN
        // Broadcast blocked by a full, stalled D, then released.
        out_ready = 4'b0111;
        Y = 4'h4; S = 2'd3; in_valid = 1'b1;
        step();
        Y = 4'h3; S = 2'd0; bcast = 1'b1;
        #1;
        chk("bc in_ready low", in_ready, 1'b0);
        step();
        out_ready = 4'b1111;
        step();
        in_valid = 1'b0; bcast = 1'b0; out_ready = 4'b0000;
        #1;
        chk("bc out_valid", out_valid, 4'b1111);
        chk("bc data", {A, B, C, D}, 16'h3333);
        out_ready = 4'b1111;
        step();
        step();
`endif

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/onebyfour_demux_router.md
Name: onebyfour_demux_router

Overview:
- Registered 1-to-4 demultiplexer: the distribution-side counterpart of the 4x1 multiplexer.
- A single valid/ready input stream carries n-bit data plus a 2-bit select S. Each word is routed into one of four output channels A/B/C/D.
- Each channel has a one-entry holding register with its own valid/ready handshake.
- Sits between a shared producer and four independent consumers. A stalled consumer blocks only traffic addressed to it.

Parameters:
- n, 4, data width of input Y and of each output channel A, B, C, D.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- Y  input  n  input data word.
- S  input  2  destination select: 00->A, 01->B, 10->C, 11->D.
- in_valid  input  1  Y/S valid this cycle.
- in_ready  output  1  router accepts Y/S this cycle.
- A, B, C, D  output  n each  channel holding-register contents.
- out_valid  output  4  bit k = channel k holds a word (bit0=A ... bit3=D).
- out_ready  input  4  bit k = consumer k takes the word this cycle.
- busy  output  1  OR of out_valid.

Behaviour:
- Reset, asynchronous on rst_n low, effective immediately:
  - out_valid=4'b0000; A=B=C=D=0; busy=0.
  - Words held when reset asserts mid-operation are discarded and not delivered.
- Transfer definitions:
  - Input accept: in_valid && in_ready at a rising edge.
  - Channel k drain: out_valid[k] && out_ready[k] at a rising edge.
- in_ready is combinational: in_ready = !out_valid[S] || out_ready[S].
  - It depends only on the addressed channel; it does not depend on in_valid.
- On accept, at the clock edge:
  - The channel selected by S loads Y and sets its out_valid bit.
  - Latency is 1 cycle: the word appears on the channel output the cycle after acceptance.
- On drain of channel k with no same-edge load into k, out_valid[k] clears. Data register k keeps its old value, which is don't-care.
- Simultaneous drain and load of the same channel: the new word replaces the old one and out_valid[k] stays 1. This sustains 1 word/cycle per channel.
- Drains of different channels, plus one load, may all occur on the same edge. The channels are independent.
- While out_valid[k]=1 and not drained, channel k data is held stable. There is no overwrite and no drop.
- Full channel: if out_valid[S]=1 and out_ready[S]=0, then in_ready=0. The producer must hold Y/S/in_valid; the word is not lost.
- Empty channel: out_valid[k]=0. out_ready[k] is ignored.
- S changing while in_valid=0 has no effect.
- busy is registered-derived (OR of the out_valid flops) and glitch-free.

Optional Feature:
- Macro: DEMUX_BCAST_EN.
- Defined: adds input port bcast (1 bit).
  - in_valid && bcast is a broadcast; S is ignored.
  - in_ready = AND over k of (!out_valid[k] || out_ready[k]).
  - On accept, all four channels load Y and all out_valid bits set.
  - Non-broadcast behaviour is unchanged.
- Undefined: no bcast port. Behaviour is exactly as above with no broadcast logic.

Test Plan:
- Reset/idle: rst_n=0 mid-stream with channel B holding 4'h7 -> out_valid=0000, B=0, busy=0 immediately, before the next clk edge.
- Basic routing: out_ready=1111; send Y=1,2,3,4 with S=00,01,10,11 on consecutive cycles -> each word appears one cycle later on A, B, C, D respectively; each out_valid bit is high for exactly 1 cycle.
- Backpressure: out_ready[2]=0; send Y=4'h9 with S=10, then Y=4'h5 with S=10 -> C=9, out_valid[2]=1, in_ready=0 while the second word is held. Raise out_ready[2] -> 9 drains and 5 loads on the same edge; C=5 the next cycle.
- Independence: channel C stalled and full; send Y=4'hA with S=00 -> in_ready=1; A=A next cycle; C is unchanged.
- Throughput: out_ready[1]=1; stream 8 words to S=01 back-to-back -> in_ready stays 1 and B shows all 8 values on 8 consecutive cycles.
- Broadcast (DEMUX_BCAST_EN defined): channel D full and stalled; send bcast Y=4'h3 -> in_ready=0. Release out_ready[3] -> A=B=C=D=3 and out_valid=1111 next cycle.
